// File: rtl/icache_pkg.sv
// Shared geometry, FSM state type and constants for the instruction-cache fill controller.
// The cache is 4 fully associative lines of 8 bytes in front of an 8-bit program ROM.
package icache_pkg;

    localparam int LINES      = 4;
    localparam int LINE_WORDS = 8;
    localparam int ADDR_W     = 8;
    localparam int ROM_LAT    = 1;

    localparam int OFFSET_W = $clog2(LINE_WORDS);
    localparam int LINE_W   = $clog2(LINES);
    localparam int TAG_W    = ADDR_W - OFFSET_W;

    localparam logic [7:0] NOP_OPCODE = 8'hC8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/icache_tag_store.sv
// Tag and valid registers for every line, with a parallel compare against the lookup tag.
// Invalidate-all wins over the single-way clear and write.
module icache_tag_store
    import icache_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [TAG_W-1:0]  lookup_tag_i,
    output logic              match_o,
    output logic [LINE_W-1:0] match_line_o,
    input  logic              inval_all_i,
    input  logic              clear_i,
    input  logic              write_i,
    input  logic [LINE_W-1:0] way_i,
    input  logic [TAG_W-1:0]  write_tag_i
);

    logic [LINES-1:0]            valid_q, valid_d;
    logic [LINES-1:0][TAG_W-1:0] tag_q, tag_d;

    // At most one way can match: a tag is only written into a line after it missed everywhere.
    always_comb begin
        match_o      = 1'b0;
        match_line_o = '0;
        for (int w = 0; w < LINES; w++) begin
            if (valid_q[w] && (tag_q[w] == lookup_tag_i)) begin
                match_o      = 1'b1;
                match_line_o = LINE_W'(w);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (inval_all_i) begin
            valid_d = '0;
        end else begin
            if (clear_i) begin
                valid_d[way_i] = 1'b0;
            end
            if (write_i) begin
                valid_d[way_i] = 1'b1;
                tag_d[way_i]   = write_tag_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache controller: hit/miss lookup, line refill from program ROM with core stall,
// round-robin victim selection and a saturating miss counter.
module icache_fill_ctrl
    import icache_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                fetch_req_i,
    input  logic [ADDR_W-1:0]   fetch_addr_i,
    input  logic                flush_i,
    output logic                hit_o,
    output logic                hold_o,
    output logic [ADDR_W-1:0]   rom_address_o,
    output logic                cache_wren_o,
    output logic [LINE_W-1:0]   cache_wrline_o,
    output logic [OFFSET_W-1:0] cache_wroffset_o,
    output logic [LINE_W-1:0]   cache_rdline_o,
    output logic [OFFSET_W-1:0] cache_rdoffset_o,
    output logic                fill_busy_o,
    output logic [7:0]          miss_count_o
);

    localparam int FILL_CYCLES = LINE_WORDS + ROM_LAT;
    localparam int CNT_W       = $clog2(FILL_CYCLES + 1);

    fill_state_e       state_q, state_d;
    logic [CNT_W-1:0]  fillCnt_q, fillCnt_d;
    logic [TAG_W-1:0]  missTag_q, missTag_d;
    logic [LINE_W-1:0] victim_q, victim_d;
    logic [LINE_W-1:0] replPtr_q, replPtr_d;
    logic [7:0]        missCount_q, missCount_d;

    logic [TAG_W-1:0]  fetchTag;
    logic              tagMatch;
    logic [LINE_W-1:0] matchLine;
    logic              startMiss;
    logic              issueActive;
    logic              writeActive;
    logic              lastWrite;
    logic              lineDone;
    logic [LINE_W-1:0] storeWay;
    logic [OFFSET_W-1:0] wrOffset;

    assign fetchTag    = fetch_addr_i[ADDR_W-1:OFFSET_W];
    assign startMiss   = (state_q == IDLE) && fetch_req_i && !tagMatch && !flush_i;
    assign issueActive = fillCnt_q < CNT_W'(LINE_WORDS);
    assign writeActive = fillCnt_q >= CNT_W'(ROM_LAT);
    assign lastWrite   = fillCnt_q == CNT_W'(FILL_CYCLES - 1);
    assign lineDone    = (state_q == DONE) && !flush_i;
    assign storeWay    = (state_q == DONE) ? victim_q : replPtr_q;
    assign wrOffset    = OFFSET_W'(fillCnt_q - CNT_W'(ROM_LAT));

    icache_tag_store u_tag_store (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .lookup_tag_i (fetchTag),
        .match_o      (tagMatch),
        .match_line_o (matchLine),
        .inval_all_i  (flush_i),
        .clear_i      (startMiss),
        .write_i      (lineDone),
        .way_i        (storeWay),
        .write_tag_i  (missTag_q)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush overrides everything and drops any fill in progress back to IDLE.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (startMiss) state_d = FILL;
                FILL:    if (lastWrite) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        hit_o            = fetch_req_i && tagMatch && !flush_i && (state_q == IDLE);
        cache_rdline_o   = hit_o ? matchLine : '0;
        cache_rdoffset_o = fetch_addr_i[OFFSET_W-1:0];
        hold_o           = (state_q != IDLE) || (fetch_req_i && !hit_o);
        fill_busy_o      = state_q != IDLE;
        cache_wren_o     = (state_q == FILL) && writeActive && !flush_i;
        cache_wrline_o   = cache_wren_o ? victim_q : '0;
        cache_wroffset_o = cache_wren_o ? wrOffset : '0;
        rom_address_o    = '0;
        if ((state_q == FILL) && issueActive) begin
            rom_address_o = {missTag_q, fillCnt_q[OFFSET_W-1:0]};
        end
        miss_count_o     = missCount_q;
    end

    // One counter covers both the ROM issue index and, ROM_LAT cycles later, the write index.
    always_comb begin
        fillCnt_d   = '0;
        missTag_d   = missTag_q;
        victim_d    = victim_q;
        replPtr_d   = replPtr_q;
        missCount_d = missCount_q;
        if ((state_q == FILL) && !flush_i && !lastWrite) begin
            fillCnt_d = fillCnt_q + CNT_W'(1);
        end
        if (startMiss) begin
            missTag_d = fetchTag;
            victim_d  = replPtr_q;
            if (missCount_q != 8'hFF) begin
                missCount_d = missCount_q + 8'd1;
            end
        end
        if (lineDone) begin
            replPtr_d = victim_q + LINE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fillCnt_q   <= '0;
            missTag_q   <= '0;
            victim_q    <= '0;
            replPtr_q   <= '0;
            missCount_q <= '0;
        end else begin
            fillCnt_q   <= fillCnt_d;
            missTag_q   <= missTag_d;
            victim_q    <= victim_d;
            replPtr_q   <= replPtr_d;
            missCount_q <= missCount_d;
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: a small tag/valid model predicts hits and victims,
// and expected cache writes are queued at each miss and popped as the DUT writes.
module tb_icache_fill_ctrl;
    import icache_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                fetchReq;
    logic [ADDR_W-1:0]   fetchAddr;
    logic                flush;
    logic                hit;
    logic                hold;
    logic [ADDR_W-1:0]   romAddress;
    logic                cacheWren;
    logic [LINE_W-1:0]   cacheWrline;
    logic [OFFSET_W-1:0] cacheWroffset;
    logic [LINE_W-1:0]   cacheRdline;
    logic [OFFSET_W-1:0] cacheRdoffset;
    logic                fillBusy;
    logic [7:0]          missCount;

    int total = 0;
    int bad   = 0;

    logic [LINE_W+OFFSET_W-1:0] wrQ[$];
    logic [LINE_W+OFFSET_W-1:0] expWr;

    logic             mValid [LINES];
    logic [TAG_W-1:0] mTag   [LINES];
    int               mPtr;
    int               mMiss;

    always #5 clk = ~clk;

    icache_fill_ctrl dut (
        .clk_i            (clk),
        .reset_ni         (rst_n),
        .fetch_req_i      (fetchReq),
        .fetch_addr_i     (fetchAddr),
        .flush_i          (flush),
        .hit_o            (hit),
        .hold_o           (hold),
        .rom_address_o    (romAddress),
        .cache_wren_o     (cacheWren),
        .cache_wrline_o   (cacheWrline),
        .cache_wroffset_o (cacheWroffset),
        .cache_rdline_o   (cacheRdline),
        .cache_rdoffset_o (cacheRdoffset),
        .fill_busy_o      (fillBusy),
        .miss_count_o     (missCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [ADDR_W-1:0] addr, input logic fl);
        fetchReq  = req;
        fetchAddr = addr;
        flush     = fl;
    endtask

    function automatic int modelLookup(input logic [ADDR_W-1:0] addr);
        for (int w = 0; w < LINES; w++) begin
            if (mValid[w] && (mTag[w] == addr[ADDR_W-1:OFFSET_W])) return w;
        end
        return -1;
    endfunction

    task automatic modelClear();
        for (int w = 0; w < LINES; w++) mValid[w] = 1'b0;
    endtask

    task automatic pushLine(input int v);
        for (int k = 0; k < LINE_WORDS; k++) begin
            wrQ.push_back({LINE_W'(v), OFFSET_W'(k)});
        end
    endtask

    // Every cache write must be the next one the model queued.
    always @(negedge clk) begin
        if (rst_n && cacheWren) begin
            checkOutput("wrExpected", 32'(wrQ.size() != 0), 32'd1);
            if (wrQ.size() != 0) begin
                expWr = wrQ.pop_front();
                checkOutput("wrLineOffset", 32'({cacheWrline, cacheWroffset}), 32'(expWr));
            end
        end
    end

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        wrQ.delete();
        modelClear();
        for (int w = 0; w < LINES; w++) mTag[w] = '0;
        mPtr  = 0;
        mMiss = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expectHit(input logic [ADDR_W-1:0] addr);
        int w;
        w = modelLookup(addr);
        applyStimulus(1'b1, addr, 1'b0);
        #2;
        checkOutput("hitFlag", 32'(hit), 32'(w >= 0));
        checkOutput("hitHold", 32'(hold), 32'(w < 0));
        checkOutput("hitRdline", 32'(cacheRdline), (w >= 0) ? 32'(w) : 32'd0);
        checkOutput("hitRdoffset", 32'(cacheRdoffset), 32'(addr[OFFSET_W-1:0]));
        checkOutput("hitMissCount", 32'(missCount), 32'(mMiss));
        @(posedge clk);
        #1;
    endtask

    task automatic doMiss(input logic [ADDR_W-1:0] addr);
        int v;
        v = mPtr;
        applyStimulus(1'b1, addr, 1'b0);
        #2;
        checkOutput("missHit", 32'(hit), 32'd0);
        checkOutput("missHold", 32'(hold), 32'd1);
        pushLine(v);
        mValid[v] = 1'b0;
        if (mMiss < 255) mMiss++;
        for (int i = 0; i < LINE_WORDS + ROM_LAT; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) fetchAddr = addr ^ 8'h80;
            #1;
            checkOutput("fillBusy", 32'(fillBusy), 32'd1);
            checkOutput("fillHold", 32'(hold), 32'd1);
            checkOutput("romAddress", 32'(romAddress),
                        (i < LINE_WORDS) ? 32'({addr[ADDR_W-1:OFFSET_W], OFFSET_W'(i)}) : 32'd0);
            if (i == 0) checkOutput("missCount", 32'(missCount), 32'(mMiss));
        end
        @(posedge clk);
        #1;
        checkOutput("doneBusy", 32'(fillBusy), 32'd1);
        mValid[v] = 1'b1;
        mTag[v]   = addr[ADDR_W-1:OFFSET_W];
        mPtr      = (v + 1) % LINES;
        @(posedge clk);
        #1;
        fetchAddr = addr;
        #2;
        checkOutput("refetchHit", 32'(hit), 32'd1);
        checkOutput("refetchHold", 32'(hold), 32'd0);
        checkOutput("refetchRdline", 32'(cacheRdline), 32'(v));
        checkOutput("refetchRdoffset", 32'(cacheRdoffset), 32'(addr[OFFSET_W-1:0]));
        checkOutput("refetchIdle", 32'(fillBusy), 32'd0);
        checkOutput("allWritesSeen", 32'(wrQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v;
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        #3;
        checkOutput("rstHit", 32'(hit), 32'd0);
        checkOutput("rstHold", 32'(hold), 32'd0);
        checkOutput("rstWren", 32'(cacheWren), 32'd0);
        checkOutput("rstBusy", 32'(fillBusy), 32'd0);
        checkOutput("rstMissCount", 32'(missCount), 32'd0);
        checkOutput("rstRomAddress", 32'(romAddress), 32'd0);
        checkOutput("rstWrline", 32'(cacheWrline), 32'd0);
        checkOutput("rstWroffset", 32'(cacheWroffset), 32'd0);
        resetDut();

        $display("[TB] cold miss and hit path");
        doMiss(8'h13);
        for (int a = 8'h10; a <= 8'h17; a++) expectHit(8'(a));

        $display("[TB] round-robin replacement");
        resetDut();
        doMiss(8'h00);
        doMiss(8'h08);
        doMiss(8'h10);
        doMiss(8'h18);
        doMiss(8'h20);
        expectHit(8'h08);
        expectHit(8'h18);
        doMiss(8'h00);

        $display("[TB] flush during fill");
        v = mPtr;
        applyStimulus(1'b1, 8'h40, 1'b0);
        #2;
        checkOutput("flushMissHold", 32'(hold), 32'd1);
        pushLine(v);
        mValid[v] = 1'b0;
        if (mMiss < 255) mMiss++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        wrQ.delete();
        applyStimulus(1'b0, 8'h40, 1'b1);
        #2;
        checkOutput("flushWrenGated", 32'(cacheWren), 32'd0);
        modelClear();
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h40, 1'b0);
        #2;
        checkOutput("flushIdle", 32'(fillBusy), 32'd0);
        checkOutput("flushMissCount", 32'(missCount), 32'(mMiss));
        doMiss(8'h40);

        $display("[TB] async reset during fill");
        applyStimulus(1'b1, 8'h80, 1'b0);
        #2;
        pushLine(mPtr);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n    = 1'b0;
        fetchReq = 1'b0;
        #1;
        checkOutput("arstHold", 32'(hold), 32'd0);
        checkOutput("arstWren", 32'(cacheWren), 32'd0);
        checkOutput("arstBusy", 32'(fillBusy), 32'd0);
        checkOutput("arstMissCount", 32'(missCount), 32'd0);
        resetDut();
        doMiss(8'h40);

        $display("[TB] miss counter saturation");
        for (int n = 0; n < 260; n++) begin
            applyStimulus(1'b1, 8'hA0, 1'b0);
            if (mMiss < 255) mMiss++;
            @(posedge clk);
            #1;
            applyStimulus(1'b0, 8'hA0, 1'b1);
            #2;
            checkOutput("satCount", 32'(missCount), 32'(mMiss));
            modelClear();
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, '0, 1'b0);
        #2;
        checkOutput("satFinal", 32'(missCount), 32'd255);
        checkOutput("satIdle", 32'(fillBusy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
